dbg_mem_initiator: RTL and testbench

- Synthesizable bus initiator that drives the picorv32-native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) on behalf of the gdbserver debug path.
- Accepts byte, half-word and word read/write commands from a host-side command port, issues exactly one bus transaction per command, and returns read data or error on a response port.
- Sits between the debug transport and the memory or bus fabric, in parallel with the core's own master port through an external arbiter.

---
 rtl/dbg_mem_pkg.sv | 37 +++
 rtl/dbg_mem_initiator_lanes.sv | 39 +++
 rtl/dbg_mem_initiator.sv | 154 +++++++++++++++
 tb/tb_dbg_mem_initiator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_mem_pkg.sv
// Shared encodings and lane helpers for the debug memory initiator.
package dbg_mem_pkg;

  localparam int         NUM_LANES = 4;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
  } cmd_t;

  function automatic logic [NUM_LANES-1:0] lane_strb(input logic [1:0] size,
                                                     input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_strb = 4'b0001 << off;
      SZ_HALF: lane_strb = 4'b0011 << off;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  // Size 3 is never legal; half and word accesses must be naturally aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    misaligned = (size == 2'd3) ||
                 ((size == SZ_HALF) && off[0]) ||
                 ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dbg_mem_initiator_lanes.sv
// Combinational lane steering: strobes, write-data replication, read extract.
module dbg_mem_lanes
  import dbg_mem_pkg::*;
(
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic [1:0]            off,
  input  logic [31:0]           wdata,
  input  logic [31:0]           rdata,
  output logic [NUM_LANES-1:0]  wstrb,
  output logic [31:0]           wdata_rep,
  output logic [31:0]           rdata_ext
);

  logic [NUM_LANES-1:0][7:0] wlane;
  logic [31:0]               rshift;

  assign wstrb = write ? lane_strb(size, off) : '0;

  // Lane i carries byte (i mod access-bytes) of the right-aligned write data.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wlane[i] = (size == SZ_BYTE) ? wdata[7:0] :
                      (size == SZ_HALF) ? wdata[8*(i%2) +: 8] :
                                          wdata[8*i +: 8];
  end

  assign wdata_rep = wlane;
  assign rshift    = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = rshift;
    case (size)
      SZ_BYTE: rdata_ext = {24'h0, rshift[7:0]};
      SZ_HALF: rdata_ext = {16'h0, rshift[15:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/dbg_mem_initiator.sv
// Debug-path bus initiator on the picorv32 native memory interface.
// Define DBG_MEM_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES.
module dbg_mem_initiator
  import dbg_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ADDR_RESET     = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_autoinc,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dbg_mem_initiator: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state;
  cmd_t        cur;
  logic [31:0] next_addr;
  logic [31:0] eff_addr;
  logic        ln_write;
  logic [1:0]  ln_size;
  logic [1:0]  ln_off;
  logic [3:0]  ln_wstrb;
  logic [31:0] ln_wdata;
  logic [31:0] ln_rdata;
  logic        wait_exp;

  assign mem_instr = 1'b0;
  assign eff_addr  = cmd_autoinc ? next_addr : cmd_addr;

  // The lane block steers the incoming command in IDLE and the latched one after.
  assign ln_write = (state == ST_IDLE) ? cmd_write     : cur.write;
  assign ln_size  = (state == ST_IDLE) ? cmd_size      : cur.size;
  assign ln_off   = (state == ST_IDLE) ? eff_addr[1:0] : cur.addr[1:0];

  dbg_mem_lanes u_lanes (
    .write     (ln_write),
    .size      (ln_size),
    .off       (ln_off),
    .wdata     (cmd_wdata),
    .rdata     (mem_rdata),
    .wstrb     (ln_wstrb),
    .wdata_rep (ln_wdata),
    .rdata_ext (ln_rdata)
  );

`ifdef DBG_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Zero outside REQ, so it is already clear on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            wait_cnt <= '0;
    else if (state == ST_REQ && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    else                                    wait_cnt <= '0;
  end

  assign wait_exp = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cur       <= '0;
      next_addr <= ADDR_RESET;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cur.write <= cmd_write;
            cur.size  <= cmd_size;
            cur.addr  <= eff_addr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (misaligned(cmd_size, eff_addr[1:0])) begin
              state     <= ST_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ST_REQ;
              mem_valid <= 1'b1;
              mem_addr  <= {eff_addr[31:2], 2'b00};
              mem_wdata <= ln_wdata;
              mem_wstrb <= ln_wstrb;
            end
          end
        end
        ST_REQ: begin
          // A completion on the limit edge wins over the timeout.
          if (mem_ready) begin
            state     <= ST_RSP;
            mem_valid <= 1'b0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= cur.write ? '0 : ln_rdata;
            next_addr <= cur.addr + (32'd1 << cur.size);
          end else if (wait_exp) begin
            state     <= ST_RSP;
            mem_valid <= 1'b0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_mem_initiator.sv
// Directed and randomized checks of dbg_mem_initiator against a byte-level memory model.
module tb_dbg_mem_initiator;

  localparam int          TMO  = 16;
  localparam logic [31:0] ARST = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_autoinc;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  logic [31:0] bus_mem [0:255];
  logic [7:0]  ref_mem [0:1023];

  int checks = 0;
  int errors = 0;

  dbg_mem_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_RESET(ARST)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_autoinc(cmd_autoinc),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = bus_mem[mem_addr[9:2]];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one command from a negedge; returns at the negedge after the response is consumed.
  task automatic do_cmd(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic ai, input logic [31:0] wd, input int rdy_pct,
                        input int stall_pct,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic bs, output logic [31:0] ba, output logic [31:0] bw,
                        output logic [3:0] bst);
    int   n;
    logic done, stable, rs_seen, rs_e;
    logic [31:0] rs_d;
    rd = '0; er = 1'b0; lat = 0; bs = 1'b0; ba = '0; bw = '0; bst = '0;
    done = 1'b0; stable = 1'b1; rs_seen = 1'b0; rs_e = 1'b0; rs_d = '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = addr;
    cmd_autoinc = ai; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    for (int c = 1; c <= 300 && !done; c++) begin
      if (mem_valid) begin
        if (!bs) begin
          bs = 1'b1; ba = mem_addr; bw = mem_wdata; bst = mem_wstrb;
        end else if (mem_addr !== ba || mem_wdata !== bw || mem_wstrb !== bst) begin
          stable = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (!rs_seen) begin
          rs_seen = 1'b1; lat = c; rs_d = rsp_rdata; rs_e = rsp_err;
        end else if (rsp_rdata !== rs_d || rsp_err !== rs_e) begin
          stable = 1'b0;
        end
        rsp_ready = ($urandom_range(99) >= stall_pct);
        if (rsp_ready) begin
          rd = rsp_rdata; er = rsp_err; done = 1'b1;
        end
      end else begin
        rsp_ready = 1'b0;
      end
      mem_ready = ($urandom_range(99) < rdy_pct);
      if (mem_valid && mem_ready)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) bus_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      @(negedge clk);
    end
    rsp_ready = 1'b0; mem_ready = 1'b0;
    chk("rsp_done", done, 1'b1);
    chk("hold_stable", stable, 1'b1);
  endtask

  logic [31:0] rd, ba, bw, a, model_next, e_rd, e_wd, v, r_addr, r_wd;
  logic [3:0]  bst, e_strb;
  logic        er, bs, r_wr, r_ai, e_err;
  logic [1:0]  r_sz;
  int          lat, nb;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0; cmd_autoinc = 0;
    cmd_wdata = 0; rsp_ready = 0; mem_ready = 0;
    for (int w = 0; w < 256; w++) bus_mem[w] = '0;

    // Reset values, applied asynchronously before any clock edge.
    #1 resetn = 1'b0;
    #2;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("mem_instr", mem_instr, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready_hold", cmd_ready, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Word write, zero-wait responder.
    do_cmd(1, 2'd2, 32'h100, 0, 32'hDEADBEEF, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("ww_addr", ba, 32'h100);
    chk("ww_strb", bst, 4'b1111);
    chk("ww_wdata", bw, 32'hDEADBEEF);
    chk("ww_err", er, 1'b0);
    chk("ww_latency", lat, 2);
    chk("ww_mem", bus_mem[32'h40], 32'hDEADBEEF);

    // Byte read from the top lane.
    bus_mem[32'h40] = 32'hAABBCCDD;
    do_cmd(0, 2'd0, 32'h103, 0, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("br_addr", ba, 32'h100);
    chk("br_strb", bst, 4'b0000);
    chk("br_rdata", rd, 32'h000000AA);
    chk("br_err", er, 1'b0);

    // Half write upper, then misaligned half write.
    do_cmd(1, 2'd1, 32'h202, 0, 32'h00001234, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("hw_strb", bst, 4'b1100);
    chk("hw_wdata", bw, 32'h12341234);
    chk("hw_addr", ba, 32'h200);
    do_cmd(1, 2'd1, 32'h201, 0, 32'h00005678, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("hmis_err", er, 1'b1);
    chk("hmis_no_bus", bs, 1'b0);
    chk("hmis_rdata", rd, 32'h0);

    // Auto-increment sequence.
    do_cmd(0, 2'd2, 32'h1000, 0, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("ai0_addr", ba, 32'h1000);
    do_cmd(0, 2'd2, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("ai1_addr", ba, 32'h1004);
    do_cmd(0, 2'd2, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("ai2_addr", ba, 32'h1008);
    do_cmd(0, 2'd2, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("ai3_addr", ba, 32'h100C);

    // Wrap of the next-address register through 2^32.
    do_cmd(0, 2'd2, 32'hFFFFFFF8, 0, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    do_cmd(0, 2'd2, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("wrap_top_addr", ba, 32'hFFFFFFFC);
    do_cmd(0, 2'd3, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("illegal_size_err", er, 1'b1);
    chk("illegal_size_no_bus", bs, 1'b0);
    do_cmd(0, 2'd0, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("wrap_zero_addr", ba, 32'h0);
    chk("wrap_zero_err", er, 1'b0);
    do_cmd(1, 2'd0, 32'h0, 1, 32'h0000005A, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("bw1_strb", bst, 4'b0010);
    chk("bw1_wdata", bw, 32'h5A5A5A5A);

`ifdef DBG_MEM_TIMEOUT_EN
    // Responder never answers; the wait aborts and the next address is untouched.
    do_cmd(0, 2'd2, 32'h300, 0, 32'h0, 0, 0, rd, er, lat, bs, ba, bw, bst);
    chk("tmo_err", er, 1'b1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_latency", lat, TMO + 1);
    do_cmd(0, 2'd1, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("tmo_next_addr", ba, 32'h0);
    chk("tmo_next_strb", bst, 4'b0000);
`endif

    // Reset asserted mid-request, away from any clock edge.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h200;
    cmd_autoinc = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("req_mem_valid", mem_valid, 1'b1);
    chk("req_busy", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_mem_valid", mem_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", cmd_ready, 1'b1);
    do_cmd(0, 2'd2, 32'h0, 1, 32'h0, 100, 0, rd, er, lat, bs, ba, bw, bst);
    chk("rst_next_addr", ba, ARST);

    // Randomized traffic against a byte-addressed reference memory.
    model_next = ARST + 32'd4;
    for (int w = 0; w < 256; w++) begin
      v = $urandom;
      bus_mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
    end
    for (int n = 0; n < 1000; n++) begin
      r_wr   = 1'($urandom_range(1));
      r_sz   = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
      r_addr = $urandom_range(1023);
      r_ai   = ($urandom_range(3) == 0);
      r_wd   = $urandom;
      a      = r_ai ? model_next : r_addr;
      nb     = 1 << r_sz;
      e_err  = (r_sz == 2'd3) || ((a % nb) != 0);
      e_rd = '0; e_wd = '0; e_strb = '0;
      if (!e_err) begin
        for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = r_wd[8*(j % nb) +: 8];
        for (int i = 0; i < nb; i++) begin
          if (r_wr) begin
            e_strb[(a % 4) + i] = 1'b1;
            ref_mem[(a + i) % 1024] = r_wd[8*i +: 8];
          end else begin
            e_rd[8*i +: 8] = ref_mem[(a + i) % 1024];
          end
        end
        model_next = a + nb;
      end
      do_cmd(r_wr, r_sz, r_addr, r_ai, r_wd, 50, 30, rd, er, lat, bs, ba, bw, bst);
      chk("rnd_err", er, e_err);
      chk("rnd_rdata", rd, e_rd);
      chk("rnd_bus", bs, !e_err);
      if (!e_err) begin
        chk("rnd_addr", ba, a & 32'hFFFF_FFFC);
        chk("rnd_strb", bst, e_strb);
        if (r_wr) chk("rnd_wdata", bw, e_wd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
